// File: rtl/aiv_video_timing_tracker.sv
// rtl/aiv_video_timing_tracker.sv - AIV raster position tracker with sync lock FSM and hsync flywheel
module aiv_video_timing_tracker #(
  parameter int DOT_DIV    = 6,
  parameter int H_TOTAL    = 864,
  parameter int H_START    = 72,
  parameter int H_ACTIVE   = 720,
  parameter int V_TOTAL    = 312,
  parameter int V_START    = 23,
  parameter int V_ACTIVE   = 288,
  parameter int INTERLACED = 1,
  parameter int H_TOL      = 2,
  parameter int LOCK_LINES = 4,
  parameter int MISS_LIMIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       isFieldOdd,
  output logic [9:0] active_dot,
  output logic [9:0] active_line,
  output logic       display_enable,
  output logic       line_start,
  output logic       frame_start,
  output logic       locked,
  output logic [1:0] sync_state
);
  localparam int DW = (DOT_DIV > 1) ? $clog2(DOT_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(DOT_DIV - 1);
  localparam logic [9:0]    DOT_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]    LINE_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]    HB        = 10'(H_START);
  localparam logic [9:0]    HE        = 10'(H_START + H_ACTIVE);
  localparam logic [9:0]    VB        = 10'(V_START);
  localparam logic [9:0]    VE        = 10'(V_START + V_ACTIVE);
  localparam logic [9:0]    GOOD_LO   = 10'(H_TOTAL - 1 - H_TOL);
  localparam logic [10:0]   GOOD_HI   = 11'(H_TOTAL - 1 + H_TOL);
  localparam logic [7:0]    LOCK_N    = 8'(LOCK_LINES);
  localparam logic [7:0]    MISS_N    = 8'(MISS_LIMIT);

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  logic          hs_q, vs_q, odd_q;
  logic [DW-1:0] div_q, div_d;
  logic [9:0]    dot_q, dot_d, line_q, line_d;
  logic [1:0]    state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [9:0]    adot_q, adot_d, aline_q, aline_d;
  logic          de_q, de_d, ls_q, ls_d, fs_q, fs_d;
  logic          hs_rise, vs_rise, dot_ce, fly_end, line_adv;
  logic          good_len, good_line, bad_line, in_active;
  logic [9:0]    field_line;

  assign hs_rise   = hsync & ~hs_q;
  assign vs_rise   = vsync & ~vs_q;
  assign dot_ce    = (div_q == DIV_LAST);
  // Flywheel: a dot wrap not caused by hsync stands in for the missing sync.
  assign fly_end   = dot_ce & (dot_q == DOT_LAST) & ~hs_rise;
  assign line_adv  = hs_rise | fly_end;
  assign good_len  = (dot_q >= GOOD_LO) & ({1'b0, dot_q} <= GOOD_HI);
  assign good_line = hs_rise & good_len;
  assign bad_line  = fly_end | (hs_rise & ~good_len);

  always_comb begin
    div_d  = div_q + 1'b1;
    dot_d  = dot_q;
    if (hs_rise) begin
      div_d = '0;
      dot_d = '0;
    end else if (dot_ce) begin
      div_d = '0;
      dot_d = (dot_q == DOT_LAST) ? 10'd0 : dot_q + 10'd1;
    end
    line_d = line_q;
    if (vs_rise) begin
      line_d = '0;
    end else if (line_adv) begin
      line_d = (line_q == LINE_LAST) ? 10'd0 : line_q + 10'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_SEARCH: begin
        if (hs_rise) begin
          state_d = ST_ACQUIRE;
          cnt_d   = '0;
        end
      end
      ST_ACQUIRE: begin
        if (good_line) begin
          if (cnt_q == LOCK_N - 8'd1) begin
            state_d = ST_LOCKED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else if (bad_line) begin
          cnt_d = '0;
        end
      end
      ST_LOCKED: begin
        if (bad_line) begin
          if (cnt_q == MISS_N - 8'd1) begin
            state_d = ST_SEARCH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else if (good_line) begin
          cnt_d = '0;
        end
      end
      default: begin
        state_d = ST_SEARCH;
        cnt_d   = '0;
      end
    endcase
  end

  assign field_line = line_q - VB;
  assign in_active  = (dot_q >= HB) && (dot_q < HE) && (line_q >= VB) && (line_q < VE) &&
                      (state_q == ST_LOCKED);

  always_comb begin
    de_d    = in_active;
    adot_d  = in_active ? dot_q - HB : 10'd0;
    aline_d = '0;
    if (in_active) begin
      aline_d = (INTERLACED != 0) ? {field_line[8:0], odd_q} : field_line;
    end
    // Pulse only on the enable edge at dot 0, so a mid-line lock never fakes a line start.
    ls_d = de_d & ~de_q & (adot_d == 10'd0);
    fs_d = ls_d & (field_line == 10'd0) & ((INTERLACED == 0) | odd_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      odd_q   <= 1'b0;
      div_q   <= '0;
      dot_q   <= '0;
      line_q  <= '0;
      state_q <= ST_SEARCH;
      cnt_q   <= '0;
      adot_q  <= '0;
      aline_q <= '0;
      de_q    <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      hs_q    <= hsync;
      vs_q    <= vsync;
      if (vs_rise) odd_q <= isFieldOdd;
      div_q   <= div_d;
      dot_q   <= dot_d;
      line_q  <= line_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adot_q  <= adot_d;
      aline_q <= aline_d;
      de_q    <= de_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  assign active_dot     = adot_q;
  assign active_line    = aline_q;
  assign display_enable = de_q;
  assign line_start     = ls_q;
  assign frame_start    = fs_q;
  assign locked         = (state_q == ST_LOCKED);
  assign sync_state     = state_q;
endmodule
